// File: rtl/me_pkg.sv
// Shared types and size helpers for the motion-estimation search path.
package me_pkg;

  localparam int ME_SAD_W = 16;

  function automatic int me_range(input int macro_dim, input int search_dim);
    return search_dim - macro_dim;
  endfunction

  function automatic int me_pos_w(input int range);
    return $clog2(range + 1);
  endfunction

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_UPDATE,
    S_DONE
  } me_state_e;

  // One bit wider than a position so the centred offset never truncates.
  localparam int ME_MV_W = me_pos_w(me_range(16, 48)) + 1;
  typedef logic signed [ME_MV_W-1:0] me_mv_t;

endpackage

// File: rtl/me_cand_counter.sv
// Raster x/y position counter over a square 0..MAX grid; also fits window address generation.
module me_cand_counter #(
  parameter int MAX = 4,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         adv_i,
  output logic [W-1:0] x_o,
  output logic [W-1:0] y_o,
  output logic         last_o
);

  logic [W-1:0] x_q, y_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (clr_i) begin
      x_q <= '0;
      y_q <= '0;
    end else if (adv_i) begin
      if (x_q == W'(MAX)) begin
        x_q <= '0;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign last_o = (x_q == W'(MAX)) && (y_q == W'(MAX));

endmodule

// File: rtl/me_search_sequencer.sv
// Full-search candidate sequencer: issues one SAD request per offset, tracks the minimum.
module me_search_sequencer
  import me_pkg::*;
#(
  parameter int MACRO_DIM  = 16,
  parameter int SEARCH_DIM = 48,
  parameter int SAD_W      = ME_SAD_W,
  localparam int RANGE     = me_range(MACRO_DIM, SEARCH_DIM),
  localparam int POS_W     = me_pos_w(RANGE),
  localparam int MV_W      = POS_W + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mb_start,
  output logic                    me_start,
  input  logic                    sad_valid,
  input  logic [SAD_W-1:0]        sad,
  output logic [POS_W-1:0]        cand_x,
  output logic [POS_W-1:0]        cand_y,
  output logic                    busy,
  output logic                    done,
  output logic signed [MV_W-1:0] best_mv_x,
  output logic signed [MV_W-1:0] best_mv_y,
  output logic [SAD_W-1:0]        best_sad
);

  localparam logic signed [MV_W-1:0] HALF = MV_W'(RANGE / 2);

  me_state_e             state_q;
  logic                  me_start_q, busy_q, done_q;
  logic [SAD_W-1:0]      min_q, best_sad_q;
  logic [POS_W-1:0]      min_x_q, min_y_q;
  logic signed [MV_W-1:0] best_x_q, best_y_q;
  logic                  last;

  me_cand_counter #(.MAX(RANGE), .W(POS_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == S_IDLE && mb_start),
    .adv_i  (state_q == S_UPDATE && !last),
    .x_o    (cand_x),
    .y_o    (cand_y),
    .last_o (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      me_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      min_q      <= '1;
      min_x_q    <= '0;
      min_y_q    <= '0;
      best_x_q   <= '0;
      best_y_q   <= '0;
      best_sad_q <= '0;
    end else begin
      me_start_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        S_IDLE: if (mb_start) begin
          state_q    <= S_ISSUE;
          me_start_q <= 1'b1;
          busy_q     <= 1'b1;
          min_q      <= '1;
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: if (sad_valid) begin
          // Strict compare keeps the earliest raster candidate on ties.
          if (sad < min_q) begin
            min_q   <= sad;
            min_x_q <= cand_x;
            min_y_q <= cand_y;
          end
          state_q <= S_UPDATE;
        end
        S_UPDATE: if (last) begin
          state_q    <= S_DONE;
          done_q     <= 1'b1;
          best_sad_q <= min_q;
          best_x_q   <= $signed({1'b0, min_x_q}) - HALF;
          best_y_q   <= $signed({1'b0, min_y_q}) - HALF;
        end else begin
          state_q    <= S_ISSUE;
          me_start_q <= 1'b1;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign me_start  = me_start_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign best_mv_x = best_x_q;
  assign best_mv_y = best_y_q;
  assign best_sad  = best_sad_q;

endmodule

// File: tb/tb_me_search_sequencer.sv
// Randomized bench with a behavioural SAD datapath and a full-search reference.
module tb_me_search_sequencer;

  localparam int MB = 4, SW = 8, SADW = 16;
  localparam int RNG = SW - MB, NPOS = RNG + 1, NC = NPOS * NPOS, LAT = 3;
  localparam int EXP_CYC = 1 + NC * (LAT + 3) + 1;

  logic clk = 1'b0, rst = 1'b1, mb_start = 1'b0, sad_valid = 1'b0;
  logic [SADW-1:0] sad = '0;
  logic me_start, busy, done;
  logic [2:0] cand_x, cand_y;
  logic signed [3:0] best_mv_x, best_mv_y;
  logic [SADW-1:0] best_sad;

  int n_cmp = 0, n_bad = 0, cyc = 0, done_cnt = 0;
  int tbl[NC];
  int issued[$];
  bit spurious = 1'b0;

  always #5 clk = ~clk;

  me_search_sequencer #(.MACRO_DIM(MB), .SEARCH_DIM(SW), .SAD_W(SADW)) dut (
    .clk(clk), .rst(rst), .mb_start(mb_start), .me_start(me_start),
    .sad_valid(sad_valid), .sad(sad), .cand_x(cand_x), .cand_y(cand_y),
    .busy(busy), .done(done), .best_mv_x(best_mv_x), .best_mv_y(best_mv_y),
    .best_sad(best_sad)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // SAD datapath: answers LAT+1 cycles after each me_start with the table entry
  // for the next raster candidate; optionally injects stray sad=0 pulses in ISSUE/UPDATE.
  initial begin : dp_model
    int cnt, pend;
    bit was_valid, real_valid;
    cnt = 0; pend = 0; was_valid = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_cnt++;
      sad_valid = 1'b0;
      real_valid = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            sad_valid = 1'b1;
            sad = SADW'(pend);
            real_valid = 1'b1;
          end
        end
        if (spurious && was_valid) begin
          sad_valid = 1'b1;
          sad = '0;
        end
        if (me_start) begin
          pend = tbl[issued.size() % NC];
          issued.push_back(int'(cand_y) * NPOS + int'(cand_x));
          cnt = LAT + 1;
          if (spurious) begin
            sad_valid = 1'b1;
            sad = '0;
          end
        end
      end
      was_valid = real_valid;
    end
  end

  task automatic run_search(input string tag, input bit spur, input bit poke);
    int best, s, k, d0;
    best = 0;
    for (int i = 1; i < NC; i++) if (tbl[i] < tbl[best]) best = i;
    issued.delete();
    spurious = spur;
    d0 = done_cnt;
    tick();
    mb_start = 1'b1;
    s = cyc;
    tick();
    mb_start = 1'b0;
    k = 0;
    while (!done && k < 3000) begin
      if (k == 5) chk({tag, "_busy"}, busy, 1);
      if (poke && k == 40) mb_start = 1'b1;
      else if (poke && k == 41) mb_start = 1'b0;
      tick();
      k++;
    end
    chk({tag, "_timeout"}, k < 3000, 1);
    // Inclusive of both the mb_start cycle and the done cycle.
    chk({tag, "_latency"}, cyc - s + 1, EXP_CYC);
    chk({tag, "_mv_x"}, best_mv_x, (best % NPOS) - RNG / 2);
    chk({tag, "_mv_y"}, best_mv_y, (best / NPOS) - RNG / 2);
    chk({tag, "_sad"}, best_sad, tbl[best]);
    if (poke) mb_start = 1'b1;
    tick();
    mb_start = 1'b0;
    chk({tag, "_done_1cyc"}, done, 0);
    chk({tag, "_busy_off"}, busy, 0);
    repeat (8) tick();
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_n_issue"}, issued.size(), NC);
    for (int i = 0; i < NC && i < issued.size(); i++) chk({tag, "_order"}, issued[i], i);
    chk({tag, "_n_done"}, done_cnt - d0, 1);
    chk({tag, "_hold_sad"}, best_sad, tbl[best]);
    spurious = 1'b0;
  endtask

  task automatic fill_rand(input int hi);
    for (int i = 0; i < NC; i++) tbl[i] = $urandom_range(0, hi);
  endtask

  initial begin : main
    int k, d0;
    for (int i = 0; i < NC; i++) tbl[i] = 0;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_me_start", me_start, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end
    chk("rst_mv_x", best_mv_x, 0);
    chk("rst_mv_y", best_mv_y, 0);
    chk("rst_sad", best_sad, 0);

    for (int i = 0; i < NC; i++) tbl[i] = 100;
    tbl[1 * NPOS + 3] = 7;
    run_search("single_min", 0, 0);

    for (int i = 0; i < NC; i++) tbl[i] = 50;
    run_search("all_tie", 0, 0);

    fill_rand(255);
    for (int i = 0; i < NC - 1; i++) if (tbl[i] == 0) tbl[i] = 1;
    tbl[NC - 1] = 0;
    run_search("last_min", 0, 0);

    for (int i = 0; i < NC; i++) tbl[i] = 100;
    tbl[1 * NPOS + 3] = 7;
    run_search("noisy", 1, 1);

    for (int r = 0; r < 3; r++) begin
      fill_rand(15);
      run_search("rand_ties", r[0], 0);
    end
    fill_rand(65534);
    run_search("rand_full", 0, 1);

    // Abort a search while candidate 10 is outstanding.
    fill_rand(1000);
    issued.delete();
    tick();
    mb_start = 1'b1;
    tick();
    mb_start = 1'b0;
    k = 0;
    while (issued.size() < 11 && k < 2000) begin
      tick();
      k++;
    end
    chk("abort_reach", k < 2000, 1);
    tick();
    tick();
    d0 = done_cnt;
    rst = 1'b1;
    tick();
    chk("abort_me_start", me_start, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cand_x", cand_x, 0);
    chk("abort_cand_y", cand_y, 0);
    chk("abort_mv_x", best_mv_x, 0);
    chk("abort_mv_y", best_mv_y, 0);
    chk("abort_sad", best_sad, 0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle_busy", busy, 0);
    fill_rand(300);
    run_search("post_abort", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/me_search_sequencer.md
Name: me_search_sequencer

Overview:
- Full-search sequencer for one macroblock of the inter-prediction (ME) datapath.
- Steps the candidate position over every integer offset of the search window in raster order and issues one start pulse per candidate to the ME controller/SAD datapath.
- Consumes each returned SAD and keeps the running minimum.
- After the last candidate, presents the best motion vector and its SAD to the mode-decision stage.

Parameters:
- MACRO_DIM, 16, macroblock edge in pixels.
- SEARCH_DIM, 48, search-window edge in pixels; RANGE = SEARCH_DIM - MACRO_DIM; positions per axis = RANGE+1.
- SAD_W, 16, SAD width; must hold MACRO_DIM*MACRO_DIM*255.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- mb_start  in  1  one-cycle pulse; begin search of a new macroblock.
- me_start  out  1  one-cycle pulse to ME controller; evaluate current candidate.
- sad_valid  in  1  one-cycle pulse from ME datapath; sad holds the result.
- sad  in  SAD_W  SAD of the candidate last issued.
- cand_x  out  $clog2(RANGE+1)  current candidate column (0..RANGE), drives search-window read offset.
- cand_y  out  $clog2(RANGE+1)  current candidate row (0..RANGE).
- busy  out  1  high from mb_start acceptance until done.
- done  out  1  one-cycle pulse; best_* valid from this cycle.
- best_mv_x  out  $clog2(RANGE+1)+1 signed  best column offset, cand_x - RANGE/2.
- best_mv_y  out  $clog2(RANGE+1)+1 signed  best row offset, cand_y - RANGE/2.
- best_sad  out  SAD_W  SAD of best candidate.

Behaviour:
- Reset (async, rst=1): state IDLE; me_start, busy, done = 0; cand_x, cand_y = 0; best_mv_x, best_mv_y, best_sad = 0.
- The FSM has five states:
  - IDLE: busy=0. mb_start=1 -> ISSUE; cand_x=cand_y=0; running min = all-ones; busy=1 next cycle.
  - ISSUE: me_start=1 for exactly one cycle -> WAIT.
  - WAIT: hold cand_x/cand_y. On sad_valid: if sad < running min (strict), load min and record position -> UPDATE. No timeout; stays in WAIT indefinitely.
  - UPDATE:
    - cand_x==RANGE and cand_y==RANGE -> DONE.
    - Otherwise cand_x+1, wrapping to 0 with cand_y+1 at cand_x==RANGE -> ISSUE.
  - DONE: done=1 one cycle; best_* registered from recorded min/position (offset by -RANGE/2, signed); busy drops -> IDLE.
- Tie rule: strict less-than; the earliest candidate in raster order wins equal SADs.
- Candidate 0 always loads, since the initial min is all-ones and SAD < 2^SAD_W-1 by construction.
- best_* update only in DONE and hold until the next DONE (not cleared by mb_start).
- Ignored inputs:
  - mb_start while busy is ignored, with no restart.
  - sad_valid outside WAIT is ignored.
  - mb_start in the DONE cycle is ignored.
- sad_valid in the same cycle as ISSUE is ignored; the datapath latency is at least 1 cycle after me_start.
- Per-candidate cost: 3 cycles (ISSUE, WAIT min 1, UPDATE) plus datapath latency L, where L = cycles from me_start to sad_valid minus 1.
- Total from mb_start to done: 1 + (RANGE+1)^2 * (L+3) + 1 cycles.
- Reset asserted mid-search aborts immediately, with all outputs at reset values. No done is produced for the aborted macroblock.
- Width rules:
  - cand counters are unsigned.
  - The mv conversion uses an explicit signed extend-then-subtract; no truncation is permitted.
  - best_mv range is -RANGE/2..+RANGE/2.

Decomposition:
- Shared package me_pkg:
  - SAD_W.
  - Derived RANGE/position widths as localparams/functions.
  - The sequencer state enum (IDLE, ISSUE, WAIT, UPDATE, DONE).
  - The mv signed type.
- One sub-module, me_cand_counter:
  - Raster x/y counter with clear, advance, and last flag.
  - Reusable for the search-window address generator.

Test Plan (bench instantiates MACRO_DIM=4, SEARCH_DIM=8 -> RANGE=4, 25 candidates; behavioural datapath model returns sad L=3 cycles after me_start):
- Reset then idle 10 cycles -> me_start, busy, done stay 0; best_* = 0.
- SAD = 100 everywhere except (cand_x=3, cand_y=1) = 7 -> one done pulse 1+25*6+1=152 cycles after mb_start; best_mv=(+1,-1); best_sad=7; exactly 25 me_start pulses in raster order.
- All SADs = 50 (tie) -> best_mv=(-2,-2); best_sad=50.
- Minimum at last candidate (4,4) = 0 -> best_mv=(+2,+2); best_sad=0; done is high exactly one cycle.
- mb_start pulsed again mid-search plus a spurious sad_valid during ISSUE/UPDATE -> no restart; result identical to the clean run.
- Assert rst during candidate 10 WAIT, release, issue mb_start -> outputs at reset values during reset; new search starts at (0,0); no stale done.
